// File: rtl/mem_rsp_model.sv
// mem_rsp_model: memory-side responder for the fill-queue memory interface.
// Requests are queued in arrival order and each entry carries its own countdown
// timer. The head retires once its timer reaches zero, at most one entry per
// cycle. A read produces a registered response carrying the full line. A write
// updates the backing line store and produces no response.

package mem_rsp_model_pkg;

  typedef logic [3:0]   t_flq_id;
  typedef logic [27:0]  t_line_addr;
  typedef logic [511:0] t_cl;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } t_mem_op;

  typedef struct packed {
    logic       valid;
    t_flq_id    id;
    t_line_addr addr;
    t_mem_op    op;
    t_cl        data;
  } t_mem_req_pkt;

  typedef struct packed {
    logic    valid;
    t_flq_id id;
    t_cl     data;
  } t_mem_rsp_pkt;

endpackage

module mem_rsp_model
  import mem_rsp_model_pkg::*;
#(
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_LINES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  t_mem_req_pkt flq_mem_req_pkt,
  output t_mem_rsp_pkt flq_mem_rsp_pkt,
  output logic         busy,
  output logic         err_overflow
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned PTR_W      = IDX_W + 1;
  localparam int unsigned LINE_W     = $clog2(NUM_LINES);
  localparam int unsigned WORDS      = $bits(t_cl) / 32;
  localparam logic [5:0]  TIMER_INIT = 6'(LATENCY - 1);

  // Parameter legality is checked once, when the design is elaborated.
  if (LATENCY < 2 || LATENCY > 64) begin : g_bad_latency
    $error("mem_rsp_model: LATENCY must lie in 2..64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_rsp_model: DEPTH must be a power of two, at least 2");
  end
  if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0) begin : g_bad_lines
    $error("mem_rsp_model: NUM_LINES must be a power of two, at least 2");
  end

  // FIFO pointers carry one wrap bit above the slot index.
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             err_overflow_reg;

  // Per-entry state: occupancy flag, countdown timer and request payload.
  logic       entry_valid_reg [DEPTH];
  logic [5:0] timer_reg       [DEPTH];
  logic [5:0] timer_dec       [DEPTH];
  t_flq_id    fifo_id_reg     [DEPTH];
  t_line_addr fifo_addr_reg   [DEPTH];
  t_mem_op    fifo_op_reg     [DEPTH];
  t_cl        fifo_data_reg   [DEPTH];

  // Head-of-queue view.
  t_flq_id           head_id;
  t_line_addr        head_addr;
  t_mem_op           head_op;
  t_cl               head_data;
  logic [LINE_W-1:0] head_line;
  t_cl               default_line;

  // Backing store: line data plus a written flag per line. The flags live in
  // flops so that reset can clear them all in one cycle.
  t_cl            line_mem [NUM_LINES];
  logic [NUM_LINES-1:0] written_reg;

  // Response register.
  logic    rsp_valid_reg;
  t_flq_id rsp_id_reg;
  t_cl     rsp_data_reg;

  assign wr_idx   = wr_ptr_reg[IDX_W-1:0];
  assign rd_idx   = rd_ptr_reg[IDX_W-1:0];
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) && (wr_idx == rd_idx);
  assign push_req = flq_mem_req_pkt.valid;

  // The head retires in the cycle its timer reaches zero. Its response is
  // registered, so it appears exactly LATENCY cycles after the request.
  assign pop  = !empty && (timer_dec[rd_idx] == 6'd0);

  // At full, a simultaneous pop frees the slot the new entry lands in.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  assign head_id   = fifo_id_reg[rd_idx];
  assign head_addr = fifo_addr_reg[rd_idx];
  assign head_op   = fifo_op_reg[rd_idx];
  assign head_data = fifo_data_reg[rd_idx];
  assign head_line = head_addr[LINE_W-1:0];

  genvar gi;

  // Pattern returned for never-written lines: word k = {addr, k}.
  for (gi = 0; gi < WORDS; gi++) begin : g_default_word
    assign default_line[gi*32 +: 32] = {head_addr, 4'(gi)};
  end

  // Per-entry timers count down and saturate at zero.
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign timer_dec[gi] = (timer_reg[gi] == 6'd0) ? 6'd0 : timer_reg[gi] - 6'd1;

    // Load on push, release on pop, otherwise age while occupied. At full the
    // popped slot and the pushed slot coincide, so the push wins.
    always_ff @(posedge clk) begin
      if (reset) begin
        entry_valid_reg[gi] <= 1'b0;
        timer_reg[gi]       <= 6'd0;
      end else if (push && (wr_idx == IDX_W'(gi))) begin
        entry_valid_reg[gi] <= 1'b1;
        timer_reg[gi]       <= TIMER_INIT;
      end else if (pop && (rd_idx == IDX_W'(gi))) begin
        entry_valid_reg[gi] <= 1'b0;
        timer_reg[gi]       <= 6'd0;
      end else if (entry_valid_reg[gi]) begin
        timer_reg[gi]       <= timer_dec[gi];
      end
    end
  end

  // Pointer advance and sticky overflow flag. A request during reset is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      err_overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (drop) begin
        err_overflow_reg <= 1'b1;
      end
    end
  end

  // Request payload capture. Payload needs no reset because occupancy is
  // tracked by the pointers and valid flags.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_reg[wr_idx]   <= flq_mem_req_pkt.id;
      fifo_addr_reg[wr_idx] <= flq_mem_req_pkt.addr;
      fifo_op_reg[wr_idx]   <= flq_mem_req_pkt.op;
      fifo_data_reg[wr_idx] <= flq_mem_req_pkt.data;
    end
  end

  // Line store write port. A retiring write lands at the end of its pop cycle.
  always_ff @(posedge clk) begin
    if (pop && (head_op == MEM_WR)) begin
      line_mem[head_line] <= head_data;
    end
  end

  // Written flags. Reset returns every line to the default pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      written_reg <= '0;
    end else if (pop && (head_op == MEM_WR)) begin
      written_reg[head_line] <= 1'b1;
    end
  end

  // Response register. The line store read is registered here, one pulse per read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= pop && (head_op == MEM_RD);
      if (pop && (head_op == MEM_RD)) begin
        rsp_id_reg   <= head_id;
        rsp_data_reg <= written_reg[head_line] ? line_mem[head_line] : default_line;
      end
    end
  end

  assign flq_mem_rsp_pkt = '{valid: rsp_valid_reg, id: rsp_id_reg, data: rsp_data_reg};
  assign busy            = !empty;
  assign err_overflow    = err_overflow_reg;

  // When the queue is at least as deep as the latency, it can never overflow.
  if (DEPTH >= LATENCY) begin : g_no_overflow
    a_no_overflow : assert property (@(posedge clk) disable iff (reset) !drop)
      else $error("mem_rsp_model: request dropped although DEPTH >= LATENCY");
  end

  // A valid request always carries a defined opcode.
  a_op_known : assert property (@(posedge clk) disable iff (reset)
    flq_mem_req_pkt.valid |-> !$isunknown(flq_mem_req_pkt.op))
    else $error("mem_rsp_model: request op is unknown");

endmodule
